// File: rtl/pe_types.sv
// Shared packet type for the processing-element edge fabric.
package pe_types;

  // Packet carried between upstream channels and the egress buffer.
  typedef struct packed {
    logic [3:0]  src;
    logic [11:0] seq;
  } packet_t;

endpackage

// File: rtl/pe_rr_pick.sv
// Combinational arbiter: round-robin from rr_ptr, or fixed priority with index 0 highest.
module pe_rr_pick #(
  parameter int NUM_IN = 4
) (
  input  logic [NUM_IN-1:0]         req,
  input  logic [$clog2(NUM_IN)-1:0] rr_ptr,
  input  logic                      rr_en,
  output logic [NUM_IN-1:0]         grant,
  output logic [$clog2(NUM_IN)-1:0] grant_idx
);

  localparam int PTR_W = $clog2(NUM_IN);

  logic [PTR_W:0]   sum_s;
  logic [PTR_W-1:0] idx_s;
  logic             found_s;

  // Scan requests from the start point (rr_ptr or 0) and pick the first active one.
  always_comb begin
    grant     = {NUM_IN{1'b0}};
    grant_idx = {PTR_W{1'b0}};
    found_s   = 1'b0;
    sum_s     = {(PTR_W+1){1'b0}};
    idx_s     = {PTR_W{1'b0}};
    for (int k = 0; k < NUM_IN; k++) begin
      if (rr_en) begin
        sum_s = {1'b0, rr_ptr} + (PTR_W+1)'(k);
      end else begin
        sum_s = (PTR_W+1)'(k);
      end
      // Wrap the scan position modulo NUM_IN (NUM_IN need not be a power of two).
      if (sum_s >= (PTR_W+1)'(NUM_IN)) begin
        sum_s = sum_s - (PTR_W+1)'(NUM_IN);
      end else begin
        sum_s = sum_s;
      end
      idx_s = sum_s[PTR_W-1:0];
      if (!found_s && req[idx_s]) begin
        found_s   = 1'b1;
        grant_idx = idx_s;
      end else begin
        found_s   = found_s;
      end
    end
    if (found_s) begin
      grant[grant_idx] = 1'b1;
    end else begin
      grant = {NUM_IN{1'b0}};
    end
  end

endmodule

// File: rtl/pe_edge_arbiter.sv
// Merges NUM_IN upstream packet channels onto one egress through a DEPTH-entry buffer.
module pe_edge_arbiter
  import pe_types::*;
#(
  parameter int NUM_IN = 4,
  parameter int DEPTH  = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       rr_en,
  output logic [NUM_IN-1:0]          in_deq,
  input  logic [NUM_IN-1:0]          in_empty,
  input  packet_t                    in_rdata [NUM_IN],
  input  logic                       out_deq,
  output logic                       out_empty,
  output packet_t                    out_rdata,
  output logic [$clog2(DEPTH+1)-1:0] occupancy
);

  localparam int PTR_W = $clog2(NUM_IN);
  localparam int AW    = $clog2(DEPTH);
  localparam int OCC_W = $clog2(DEPTH+1);

  logic [NUM_IN-1:0] req_s;
  logic [NUM_IN-1:0] grant_s;
  logic [PTR_W-1:0]  grant_idx_s;
  logic [PTR_W-1:0]  rr_ptr_r;
  logic              can_push_s;
  logic              push_s;
  logic              pop_s;

  packet_t           mem_r [DEPTH];
  logic [AW-1:0]     wr_ptr_r;
  logic [AW-1:0]     rd_ptr_r;
  logic [OCC_W-1:0]  occ_r;

  // Requests are only offered when the buffer had room at cycle start and reset is low;
  // a same-cycle pop deliberately does not open a slot for this cycle's grant.
  always_comb begin
    can_push_s = 1'b0;
    req_s      = {NUM_IN{1'b0}};
    if (!rst && (occ_r < OCC_W'(DEPTH))) begin
      can_push_s = 1'b1;
      req_s      = ~in_empty;
    end else begin
      can_push_s = 1'b0;
      req_s      = {NUM_IN{1'b0}};
    end
    push_s = |grant_s;
    pop_s  = out_deq && (occ_r != {OCC_W{1'b0}});
  end

  pe_rr_pick #(
    .NUM_IN (NUM_IN)
  ) u_pick (
    .req       (req_s),
    .rr_ptr    (rr_ptr_r),
    .rr_en     (rr_en),
    .grant     (grant_s),
    .grant_idx (grant_idx_s)
  );

  // Round-robin pointer advances past the granted channel; it holds in fixed-priority mode.
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr_r <= {PTR_W{1'b0}};
    end else if (push_s && rr_en) begin
      if (grant_idx_s == PTR_W'(NUM_IN-1)) begin
        rr_ptr_r <= {PTR_W{1'b0}};
      end else begin
        rr_ptr_r <= grant_idx_s + PTR_W'(1);
      end
    end else begin
      rr_ptr_r <= rr_ptr_r;
    end
  end

  // Buffer pointers and occupancy; pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      occ_r    <= {OCC_W{1'b0}};
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + AW'(1);
      end else begin
        wr_ptr_r <= wr_ptr_r;
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + AW'(1);
      end else begin
        rd_ptr_r <= rd_ptr_r;
      end
      case ({push_s, pop_s})
        2'b10:   occ_r <= occ_r + OCC_W'(1);
        2'b01:   occ_r <= occ_r - OCC_W'(1);
        default: occ_r <= occ_r;
      endcase
    end
  end

  // Storage array is not reset; entries are only read after being written.
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_r[wr_ptr_r] <= in_rdata[grant_idx_s];
    end else begin
      mem_r[wr_ptr_r] <= mem_r[wr_ptr_r];
    end
  end

  assign in_deq    = grant_s;
  assign out_empty = (occ_r == {OCC_W{1'b0}});
  assign out_rdata = mem_r[rd_ptr_r];
  assign occupancy = occ_r;

endmodule
